// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core and its program sequencer:
// sequencer state encoding, instruction field layout and opcode groups.
package cpu_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_ISSUE  = 3'd2,
    SEQ_ARM    = 3'd3,
    SEQ_EXEC   = 3'd4,
    SEQ_HALTED = 3'd5,
    SEQ_ERROR  = 3'd6
  } seq_state_t;

  // Sequencer defaults
  localparam logic [3:0]  HALT_OPCD_DEF   = 4'hF;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  // Instruction field bit positions (shared with the core decoder)
  localparam int OPCD_MSB = 31;
  localparam int OPCD_LSB = 28;
  localparam int RD_MSB   = 27;
  localparam int RD_LSB   = 24;
  localparam int RS_MSB   = 23;
  localparam int RS_LSB   = 20;
  localparam int SUB_MSB  = 19;
  localparam int SUB_LSB  = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // Opcode groups
  localparam logic [3:0] GRP_NOP  = 4'h0;
  localparam logic [3:0] GRP_LD   = 4'h1;
  localparam logic [3:0] GRP_IO   = 4'h2;
  localparam logic [3:0] GRP_MATH = 4'h3;
  localparam logic [3:0] GRP_HALT = 4'hF;

  // IO group sub-opcodes
  localparam logic [3:0] IO_IN  = 4'h0;
  localparam logic [3:0] IO_OUT = 4'h1;

  // Math group sub-opcodes
  localparam logic [3:0] MATH_ADD = 4'h0;
  localparam logic [3:0] MATH_SUB = 4'h1;
  localparam logic [3:0] MATH_AND = 4'h2;
  localparam logic [3:0] MATH_OR  = 4'h3;
  localparam logic [3:0] MATH_XOR = 4'h4;
  localparam logic [3:0] MATH_SHL = 4'h5;
  localparam logic [3:0] MATH_SHR = 4'h6;

  // Opcode field of an instruction word
  function automatic logic [3:0] inst_opcd(input logic [31:0] inst);
    return inst[OPCD_MSB:OPCD_LSB];
  endfunction

  // Assemble an instruction word from its fields
  function automatic logic [31:0] mk_inst(input logic [3:0]  opcd,
                                          input logic [3:0]  rd,
                                          input logic [3:0]  rs,
                                          input logic [3:0]  sub,
                                          input logic [15:0] imm);
    return {opcd, rd, rs, sub, imm};
  endfunction

  // States in which the sequencer owns an in-flight fetch or instruction
  function automatic logic is_busy_state(input seq_state_t s);
    return (s == SEQ_FETCH) || (s == SEQ_ISSUE) ||
           (s == SEQ_ARM)   || (s == SEQ_EXEC);
  endfunction

endpackage

// File: rtl/cpu_seq_wdog.sv
// Watchdog for the sequencer: clearable, enabled cycle counter that flags
// the TIMEOUT_CYC-th enabled cycle since the last clear.
module seq_wdog
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  // expired is raised during the last allowed cycle so the owner can leave
  // its wait state on exactly the TIMEOUT_CYC-th cycle
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Count enabled cycles; clear has priority and the count saturates at expiry
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Program sequencer: fetches instruction words, issues them to the cpu core
// one at a time and waits for completion, with start/stop, HALT detection
// and a watchdog on both the fetch and the execute phases.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [3:0]  HALT_OPCD   = HALT_OPCD_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        seq_start,
  input  logic        seq_stop,
  input  logic [31:0] seq_base_addr,
  output logic        seq_busy,
  output logic        seq_halted,
  output logic        seq_err,
  output logic [31:0] seq_pc,
  output logic [31:0] seq_icount,
  output logic        fetch_ctr,
  output logic [31:0] fetch_addr,
  input  logic        fetch_done,
  input  logic [31:0] fetch_data,
  output logic [31:0] sys_inst_cmd,
  output logic        sys_inst_up,
  input  logic        sys_inst_st
);

  seq_state_t  r_state;
  seq_state_t  w_state_next;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_icount;
  logic [31:0] w_icount_next;
  logic [31:0] r_cmd;
  logic [31:0] w_cmd_next;
  logic        r_fetch_ctr;
  logic        w_fetch_ctr_next;
  logic        r_inst_up;
  logic        w_inst_up_next;
  logic        r_stop_pend;
  logic        w_stop_pend_next;

  logic        w_busy;
  logic        w_start_ok;
  logic        w_stop_req;
  logic        w_wd_clr;
  logic        w_wd_en;
  logic        w_wd_expired;

  // A simultaneous stop cancels a start; a stop seen together with core
  // completion counts as already pending
  assign w_busy     = is_busy_state(r_state);
  assign w_start_ok = seq_start && !seq_stop;
  assign w_stop_req = r_stop_pend || seq_stop;

  seq_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-value decode for every registered output
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_icount_next = r_icount;
    w_cmd_next    = r_cmd;

    case (r_state)
      SEQ_IDLE, SEQ_HALTED, SEQ_ERROR: begin
        if (w_start_ok) begin
          w_state_next  = SEQ_FETCH;
          w_pc_next     = seq_base_addr;
          w_icount_next = 32'd0;
        end
      end
      SEQ_FETCH: begin
        // a completing fetch wins over a watchdog expiring in the same cycle
        if (fetch_done) begin
          w_cmd_next   = fetch_data;
          w_state_next = (inst_opcd(fetch_data) == HALT_OPCD) ? SEQ_HALTED : SEQ_ISSUE;
        end else if (w_wd_expired) begin
          w_state_next = SEQ_ERROR;
        end
      end
      SEQ_ISSUE: begin
        w_state_next = SEQ_ARM;
      end
      SEQ_ARM: begin
        // core status is stale here; it has not yet reacted to the strobe
        w_state_next = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        if (sys_inst_st) begin
          w_pc_next     = r_pc + 32'd1;
          w_icount_next = r_icount + 32'd1;
          w_state_next  = w_stop_req ? SEQ_IDLE : SEQ_FETCH;
        end else if (w_wd_expired) begin
          w_state_next = SEQ_ERROR;
        end
      end
      default: begin
        w_state_next = SEQ_IDLE;
      end
    endcase

    // fetch request mirrors the FETCH state one register stage ahead
    w_fetch_ctr_next = (w_state_next == SEQ_FETCH);
    // the strobe is registered from ISSUE, so it rises one cycle after the
    // command register has loaded and the core always sees a settled word
    w_inst_up_next   = (r_state == SEQ_ISSUE);

    // watchdog restarts on entry to each wait phase
    w_wd_clr = (w_state_next != r_state) &&
               ((w_state_next == SEQ_FETCH) || (w_state_next == SEQ_ARM));
    w_wd_en  = (r_state == SEQ_FETCH) || (r_state == SEQ_EXEC);

    // stop request survives only while the sequencer stays busy
    w_stop_pend_next = is_busy_state(w_state_next) ? (r_stop_pend || (w_busy && seq_stop)) : 1'b0;
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_pc        <= 32'd0;
      r_icount    <= 32'd0;
      r_cmd       <= 32'd0;
      r_fetch_ctr <= 1'b0;
      r_inst_up   <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_icount    <= w_icount_next;
      r_cmd       <= w_cmd_next;
      r_fetch_ctr <= w_fetch_ctr_next;
      r_inst_up   <= w_inst_up_next;
      r_stop_pend <= w_stop_pend_next;
    end
  end

  assign seq_busy     = w_busy;
  assign seq_halted   = (r_state == SEQ_HALTED);
  assign seq_err      = (r_state == SEQ_ERROR);
  assign seq_pc       = r_pc;
  assign seq_icount   = r_icount;
  assign fetch_ctr    = r_fetch_ctr;
  assign fetch_addr   = r_pc;
  assign sys_inst_cmd = r_cmd;
  assign sys_inst_up  = r_inst_up;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq with a small program memory and a minimal core.
module tb_cpu_seq;
  import cpu_pkg::*;

  localparam int unsigned TO_CYC = 1024;

  logic        sys_clk;
  logic        sys_rst;
  logic        seq_start;
  logic        seq_stop;
  logic [31:0] seq_base_addr;
  logic        seq_busy;
  logic        seq_halted;
  logic        seq_err;
  logic [31:0] seq_pc;
  logic [31:0] seq_icount;
  logic        fetch_ctr;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_data;
  logic [31:0] sys_inst_cmd;
  logic        sys_inst_up;
  logic        sys_inst_st;

  cpu_seq #(
    .TIMEOUT_CYC (TO_CYC),
    .HALT_OPCD   (4'hF)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .seq_start     (seq_start),
    .seq_stop      (seq_stop),
    .seq_base_addr (seq_base_addr),
    .seq_busy      (seq_busy),
    .seq_halted    (seq_halted),
    .seq_err       (seq_err),
    .seq_pc        (seq_pc),
    .seq_icount    (seq_icount),
    .fetch_ctr     (fetch_ctr),
    .fetch_addr    (fetch_addr),
    .fetch_done    (fetch_done),
    .fetch_data    (fetch_data),
    .sys_inst_cmd  (sys_inst_cmd),
    .sys_inst_up   (sys_inst_up),
    .sys_inst_st   (sys_inst_st)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      n_pass++;
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- program memory model ----------------
  logic [31:0] m_addr [16];
  logic [31:0] m_data [16];
  int          m_n;
  logic        mem_en;
  int          mem_lat;
  int          f_wait;

  task automatic add_word(input logic [31:0] a, input logic [31:0] d);
    m_addr[m_n] = a;
    m_data[m_n] = d;
    m_n++;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < m_n; i++) begin
      if (m_addr[i] == a) d = m_data[i];
    end
    return d;
  endfunction

  // memory answers after mem_lat wait cycles, driven mid-cycle
  always @(negedge sys_clk) begin
    fetch_data = mem_rd(fetch_addr);
    if (fetch_ctr && mem_en) begin
      fetch_done = (f_wait >= mem_lat);
      f_wait     = f_wait + 1;
    end else begin
      fetch_done = 1'b0;
      f_wait     = 0;
    end
  end

  // ---------------- core model ----------------
  logic        core_st;
  int          core_cnt;
  int          core_lat;
  int          up_count;
  logic [31:0] core_reg [16];

  assign sys_inst_st = core_st;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      core_st  <= 1'b1;
      core_cnt <= 0;
      for (int i = 0; i < 16; i++) core_reg[i] <= 32'h0;
    end else if (sys_inst_up) begin
      core_st  <= 1'b0;
      core_cnt <= core_lat;
      up_count <= up_count + 1;
      if (sys_inst_cmd[31:28] == GRP_LD)
        core_reg[sys_inst_cmd[27:24]] <= {16'h0, sys_inst_cmd[15:0]};
    end else if (!core_st) begin
      if (core_cnt == 0) core_st <= 1'b1;
      else core_cnt <= core_cnt - 1;
    end
  end

  // ---------------- protocol monitor ----------------
  int          viol;
  int          fetch_rises;
  logic        last_up;
  logic        last_fc;
  logic [31:0] last_cmd;

  initial begin
    viol        = 0;
    fetch_rises = 0;
    last_up     = 1'b0;
    last_fc     = 1'b0;
    last_cmd    = 32'h0;
    up_count    = 0;
  end

  // strobe must be one cycle wide and the command settled a cycle before it
  always @(negedge sys_clk) begin
    if (sys_inst_up && last_up) viol++;
    if (sys_inst_up && !last_up && (sys_inst_cmd != last_cmd)) viol++;
    if (fetch_ctr && !last_fc) fetch_rises++;
    last_up  = sys_inst_up;
    last_fc  = fetch_ctr;
    last_cmd = sys_inst_cmd;
  end

  task automatic start_at(input logic [31:0] base);
    seq_base_addr = base;
    seq_start     = 1'b1;
    tick();
    seq_start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (seq_busy && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(seq_busy), 32'd0);
  endtask

  int up0;
  int fr0;
  int n;
  int n_up;

  initial begin
    sys_rst       = 1'b0;
    seq_start     = 1'b0;
    seq_stop      = 1'b0;
    seq_base_addr = 32'h0;
    mem_en        = 1'b1;
    mem_lat       = 0;
    core_lat      = 0;
    m_n           = 0;
    f_wait        = 0;
    fetch_done    = 1'b0;
    fetch_data    = 32'h0;

    add_word(32'h0000_0010, mk_inst(GRP_LD, 4'd1, 4'd0, 4'd0, 16'd5));
    add_word(32'h0000_0011, mk_inst(GRP_LD, 4'd2, 4'd0, 4'd0, 16'd7));
    add_word(32'h0000_0012, 32'hF000_0000);
    add_word(32'h0000_0020, mk_inst(GRP_LD, 4'd3, 4'd0, 4'd0, 16'h0009));
    add_word(32'h0000_0021, mk_inst(GRP_LD, 4'd4, 4'd0, 4'd0, 16'h0044));
    add_word(32'h0000_0022, mk_inst(GRP_LD, 4'd5, 4'd0, 4'd0, 16'h0001));
    add_word(32'h0000_0023, 32'hF000_0000);
    add_word(32'h0000_0040, 32'hF000_0000);
    add_word(32'hFFFF_FFFF, mk_inst(GRP_LD, 4'd6, 4'd0, 4'd0, 16'h0066));
    add_word(32'h0000_0000, 32'hF000_0000);
    add_word(32'h0000_0050, mk_inst(GRP_LD, 4'd7, 4'd0, 4'd0, 16'h0001));
    add_word(32'h0000_0051, 32'hF000_0000);

    // ---- reset values ----
    repeat (3) tick();
    chk("rst_busy",   32'(seq_busy),    32'd0);
    chk("rst_halted", 32'(seq_halted),  32'd0);
    chk("rst_err",    32'(seq_err),     32'd0);
    chk("rst_pc",     seq_pc,           32'd0);
    chk("rst_icount", seq_icount,       32'd0);
    chk("rst_fctr",   32'(fetch_ctr),   32'd0);
    chk("rst_faddr",  fetch_addr,       32'd0);
    chk("rst_cmd",    sys_inst_cmd,     32'd0);
    chk("rst_up",     32'(sys_inst_up), 32'd0);
    sys_rst = 1'b1;
    tick();

    // ---- two instructions then halt ----
    up0 = up_count;
    start_at(32'h10);
    chk("t1_fctr_rise", 32'(fetch_ctr), 32'd1);
    chk("t1_faddr",     fetch_addr,     32'h10);
    wait_idle("t1", 200);
    chk("t1_halted", 32'(seq_halted),        32'd1);
    chk("t1_icount", seq_icount,             32'd2);
    chk("t1_pc",     seq_pc,                 32'h12);
    chk("t1_ups",    32'(up_count - up0),    32'd2);
    chk("t1_reg1",   core_reg[1],            32'd5);
    chk("t1_reg2",   core_reg[2],            32'd7);
    chk("t1_cmd",    sys_inst_cmd,           32'hF000_0000);
    chk("t1_fctr",   32'(fetch_ctr),         32'd0);

    // ---- fetch wait states and stop during second EXEC ----
    mem_lat  = 3;
    core_lat = 2;
    up0 = up_count;
    fr0 = fetch_rises;
    start_at(32'h20);
    chk("t2_clr_halted", 32'(seq_halted), 32'd0);
    n = 0;
    n_up = 0;
    while (n_up < 2 && n < 300) begin
      tick();
      n++;
      if (sys_inst_up) n_up++;
    end
    chk("t2_up_seen", 32'(n_up), 32'd2);
    tick();
    seq_stop = 1'b1;
    tick();
    seq_stop = 1'b0;
    wait_idle("t2", 200);
    chk("t2_halted",  32'(seq_halted),           32'd0);
    chk("t2_icount",  seq_icount,                32'd2);
    chk("t2_pc",      seq_pc,                    32'h22);
    chk("t2_fetches", 32'(fetch_rises - fr0),    32'd2);
    chk("t2_ups",     32'(up_count - up0),       32'd2);
    chk("t2_reg4",    core_reg[4],               32'h44);
    chk("t2_reg5",    core_reg[5],               32'h0);
    repeat (3) tick();
    chk("t2_no_fetch", 32'(fetch_ctr), 32'd0);

    // ---- fetch timeout ----
    mem_lat  = 0;
    core_lat = 0;
    mem_en   = 1'b0;
    start_at(32'h40);
    n = 0;
    while (!seq_err && n < 3000) begin
      if (fetch_ctr) n++;
      tick();
    end
    chk("t3_fetch_cyc", 32'(n),          TO_CYC);
    chk("t3_err",       32'(seq_err),    32'd1);
    chk("t3_fctr",      32'(fetch_ctr),  32'd0);
    chk("t3_busy",      32'(seq_busy),   32'd0);
    chk("t3_pc",        seq_pc,          32'h40);
    mem_en = 1'b1;
    start_at(32'h40);
    chk("t3_err_clr",   32'(seq_err),    32'd0);
    chk("t3_refetch",   32'(fetch_ctr),  32'd1);
    wait_idle("t3", 50);
    chk("t3_halted",    32'(seq_halted), 32'd1);
    chk("t3_icount",    seq_icount,      32'd0);

    // ---- PC wrap ----
    core_lat = 1;
    start_at(32'hFFFF_FFFF);
    chk("t4_faddr0", fetch_addr, 32'hFFFF_FFFF);
    wait_idle("t4", 200);
    chk("t4_halted", 32'(seq_halted), 32'd1);
    chk("t4_faddr",  fetch_addr,      32'h0);
    chk("t4_icount", seq_icount,      32'd1);
    chk("t4_reg6",   core_reg[6],     32'h66);

    // ---- reset during EXEC ----
    core_lat = 20;
    start_at(32'h50);
    n = 0;
    while (!sys_inst_up && n < 50) begin
      tick();
      n++;
    end
    chk("t5_up_seen", 32'(sys_inst_up), 32'd1);
    tick();
    tick();
    chk("t5_busy_pre", 32'(seq_busy), 32'd1);
    chk("t5_cmd_pre",  sys_inst_cmd,  mk_inst(GRP_LD, 4'd7, 4'd0, 4'd0, 16'h0001));
    #2;
    sys_rst = 1'b0;
    #1;
    chk("t5_busy",   32'(seq_busy),    32'd0);
    chk("t5_pc",     seq_pc,           32'd0);
    chk("t5_faddr",  fetch_addr,       32'd0);
    chk("t5_cmd",    sys_inst_cmd,     32'd0);
    chk("t5_icount", seq_icount,       32'd0);
    chk("t5_fctr",   32'(fetch_ctr),   32'd0);
    chk("t5_up",     32'(sys_inst_up), 32'd0);
    chk("t5_flags",  {30'd0, seq_halted, seq_err}, 32'd0);
    tick();
    sys_rst = 1'b1;
    tick();
    tick();
    chk("t5_idle_busy", 32'(seq_busy),  32'd0);
    chk("t5_idle_fctr", 32'(fetch_ctr), 32'd0);

    // ---- start/stop collision and start while busy ----
    core_lat      = 0;
    seq_base_addr = 32'h10;
    seq_start     = 1'b1;
    seq_stop      = 1'b1;
    tick();
    seq_start     = 1'b0;
    seq_stop      = 1'b0;
    chk("t6_col_busy", 32'(seq_busy),  32'd0);
    chk("t6_col_fctr", 32'(fetch_ctr), 32'd0);
    tick();
    chk("t6_col_fctr2", 32'(fetch_ctr), 32'd0);
    chk("t6_col_pc",    seq_pc,         32'd0);
    start_at(32'h10);
    tick();
    start_at(32'h99);
    chk("t6_busy_pc",  seq_pc,         32'h10);
    chk("t6_busy",     32'(seq_busy),  32'd1);
    wait_idle("t6", 200);
    chk("t6_halted",   32'(seq_halted), 32'd1);
    chk("t6_pc",       seq_pc,          32'h12);
    chk("t6_icount",   seq_icount,      32'd2);

    chk("mon_viol", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
